// File: rtl/jtframe_tilerom_rsp.sv
// rtl/jtframe_tilerom_rsp.sv - tile ROM responder with one-entry tag buffer over a 16-bit SDRAM slot
// A hit answers combinationally; a miss fetches two little-endian beats and refills the buffer.
module jtframe_tilerom_rsp #(
  parameter int             AW     = 15,
  parameter int             SDW    = 22,
  parameter logic [SDW-1:0] OFFSET = '0
) (
  input  logic            rst,
  input  logic            clk,
  input  logic            cs,
  input  logic [AW-1:0]   addr,
  output logic [31:0]     dout,
  output logic            ok,
  output logic [SDW-1:0]  sdram_addr,
  output logic            req,
  input  logic            ack,
  input  logic            din_ok,
  input  logic [15:0]     din
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  tag_q, tag_d;
  logic [AW-1:0]  pend_q, pend_d;
  logic [31:0]    data_q, data_d;
  logic [15:0]    lo_q, lo_d;
  logic           valid_q, valid_d;
  logic           beat_q, beat_d;
  logic           req_q, req_d;
  logic [SDW-1:0] sdram_addr_q, sdram_addr_d;

  logic           hit;
  logic [SDW-1:0] word_addr;

  // Each 32-bit tile word spans two 16-bit SDRAM words; wrap is modular in SDW bits.
  assign word_addr  = SDW'({addr, 1'b0});
  assign hit        = valid_q & (addr == tag_q);
  assign ok         = cs & hit;
  assign dout       = data_q;
  assign req        = req_q;
  assign sdram_addr = sdram_addr_q;

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    pend_d       = pend_q;
    data_d       = data_q;
    lo_d         = lo_q;
    valid_d      = valid_q;
    beat_d       = beat_q;
    req_d        = req_q;
    sdram_addr_d = sdram_addr_q;
    case (state_q)
      IDLE: begin
        if (cs && !hit) begin
          pend_d       = addr;
          sdram_addr_d = word_addr + OFFSET;
          req_d        = 1'b1;
          state_d      = REQ;
        end
      end
      REQ: begin
        // Data arriving with or before ack belongs to no fetch of ours.
        if (ack) begin
          req_d   = 1'b0;
          beat_d  = 1'b0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (din_ok) begin
          if (!beat_q) begin
            lo_d   = din;
            beat_d = 1'b1;
          end else begin
            // Fill with the latched address so a moved addr cannot alias this data.
            data_d  = {din, lo_q};
            tag_d   = pend_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      pend_q       <= '0;
      data_q       <= '0;
      lo_q         <= '0;
      valid_q      <= 1'b0;
      beat_q       <= 1'b0;
      req_q        <= 1'b0;
      sdram_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      pend_q       <= pend_d;
      data_q       <= data_d;
      lo_q         <= lo_d;
      valid_q      <= valid_d;
      beat_q       <= beat_d;
      req_q        <= req_d;
      sdram_addr_q <= sdram_addr_d;
    end
  end

endmodule

// File: tb/tb_jtframe_tilerom_rsp.sv
// tb/tb_jtframe_tilerom_rsp.sv - directed self-checking bench for jtframe_tilerom_rsp
module tb_jtframe_tilerom_rsp;

  logic        clk;
  logic        rst;
  logic        cs;
  logic [14:0] addr;
  logic        ack;
  logic        din_ok;
  logic [15:0] din;

  logic [31:0] dout0, dout1, dout2;
  logic        ok0, ok1, ok2;
  logic [21:0] sa0, sa1, sa2;
  logic        req0, req1, req2;

  int checks = 0;
  int errors = 0;

  jtframe_tilerom_rsp dut0 (
    .rst(rst), .clk(clk), .cs(cs), .addr(addr), .dout(dout0), .ok(ok0),
    .sdram_addr(sa0), .req(req0), .ack(ack), .din_ok(din_ok), .din(din)
  );

  jtframe_tilerom_rsp #(.OFFSET(22'h100000)) dut1 (
    .rst(rst), .clk(clk), .cs(cs), .addr(addr), .dout(dout1), .ok(ok1),
    .sdram_addr(sa1), .req(req1), .ack(ack), .din_ok(din_ok), .din(din)
  );

  jtframe_tilerom_rsp #(.OFFSET(22'h3FFFFE)) dut2 (
    .rst(rst), .clk(clk), .cs(cs), .addr(addr), .dout(dout2), .ok(ok2),
    .sdram_addr(sa2), .req(req2), .ack(ack), .din_ok(din_ok), .din(din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b0; addr = '0; ack = 1'b0; din_ok = 1'b0; din = '0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    #1;
    checks++; if (req0 !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", req0); end
    checks++; if (ok0 !== 1'b0) begin errors++; $display("FAIL reset_ok: got %b expected 0", ok0); end
    checks++; if (dout0 !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h expected 00000000", dout0); end
    checks++; if (sa0 !== 22'h0) begin errors++; $display("FAIL reset_sdram_addr: got %h expected 000000", sa0); end
  endtask

  task automatic test_miss();
    cs = 1'b1; addr = 15'h0010;
    #1;
    checks++; if (ok0 !== 1'b0) begin errors++; $display("FAIL miss_ok_low: got %b expected 0", ok0); end
    cyc();
    checks++; if (req0 !== 1'b1) begin errors++; $display("FAIL miss_req: got %b expected 1", req0); end
    checks++; if (sa0 !== 22'h000020) begin errors++; $display("FAIL miss_sdram_addr: got %h expected 000020", sa0); end
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    checks++; if (req0 !== 1'b0) begin errors++; $display("FAIL miss_req_drop: got %b expected 0", req0); end
    din_ok = 1'b1; din = 16'h1234;
    cyc();
    din = 16'hABCD;
    cyc();
    din_ok = 1'b0;
    #1;
    checks++; if (ok0 !== 1'b1) begin errors++; $display("FAIL miss_fill_ok: got %b expected 1", ok0); end
    checks++; if (dout0 !== 32'hABCD1234) begin errors++; $display("FAIL miss_fill_dout: got %h expected abcd1234", dout0); end
  endtask

  task automatic test_hit();
    cs = 1'b0;
    cyc(); cyc();
    cs = 1'b1; addr = 15'h0010;
    #1;
    checks++; if (ok0 !== 1'b1) begin errors++; $display("FAIL hit_ok_same_cycle: got %b expected 1", ok0); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      checks++; if (req0 !== 1'b0) begin errors++; $display("FAIL hit_no_req: got %b expected 0", req0); end
    end
    addr = 15'h0011;
    #1;
    checks++; if (ok0 !== 1'b0) begin errors++; $display("FAIL hit_new_addr_ok: got %b expected 0", ok0); end
    cyc();
    checks++; if (req0 !== 1'b1) begin errors++; $display("FAIL hit_new_req: got %b expected 1", req0); end
    checks++; if (sa0 !== 22'h000022) begin errors++; $display("FAIL hit_new_sdram_addr: got %h expected 000022", sa0); end
    ack = 1'b1;
    cyc();
    ack = 1'b0; din_ok = 1'b1; din = 16'h5555;
    cyc();
    din = 16'h6666;
    cyc();
    din_ok = 1'b0;
    #1;
    checks++; if (dout0 !== 32'h66665555 || ok0 !== 1'b1) begin errors++; $display("FAIL hit_refill: got ok=%b dout=%h expected ok=1 dout=66665555", ok0, dout0); end
  endtask

  task automatic test_offset();
    cs = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0; cs = 1'b1; addr = 15'h7FFF;
    cyc();
    checks++; if (sa1 !== 22'h10FFFE || req1 !== 1'b1) begin errors++; $display("FAIL offset_high: got req=%b addr=%h expected req=1 addr=10fffe", req1, sa1); end
    checks++; if (sa0 !== 22'h00FFFE) begin errors++; $display("FAIL offset_zero_top: got %h expected 00fffe", sa0); end
    rst = 1'b1; cs = 1'b0;
    cyc();
    rst = 1'b0; cs = 1'b1; addr = 15'h0001;
    cyc();
    checks++; if (sa2 !== 22'h000000 || req2 !== 1'b1) begin errors++; $display("FAIL offset_wrap: got req=%b addr=%h expected req=1 addr=000000", req2, sa2); end
    rst = 1'b1; cs = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_addr_change();
    cs = 1'b1; addr = 15'h0020;
    cyc();
    checks++; if (sa0 !== 22'h000040 || req0 !== 1'b1) begin errors++; $display("FAIL chg_first_req: got req=%b addr=%h expected req=1 addr=000040", req0, sa0); end
    ack = 1'b1;
    cyc();
    ack = 1'b0; addr = 15'h0030; din_ok = 1'b1; din = 16'h1111;
    cyc();
    din = 16'h2222;
    cyc();
    din_ok = 1'b0;
    #1;
    checks++; if (ok0 !== 1'b0) begin errors++; $display("FAIL chg_ok_low: got %b expected 0", ok0); end
    checks++; if (dut0.tag_q !== 15'h0020) begin errors++; $display("FAIL chg_tag: got %h expected 0020", dut0.tag_q); end
    checks++; if (dout0 !== 32'h22221111) begin errors++; $display("FAIL chg_data: got %h expected 22221111", dout0); end
    checks++; if (req0 !== 1'b0) begin errors++; $display("FAIL chg_no_req_at_fill: got %b expected 0", req0); end
    cyc();
    checks++; if (req0 !== 1'b1 || sa0 !== 22'h000060) begin errors++; $display("FAIL chg_second_req: got req=%b addr=%h expected req=1 addr=000060", req0, sa0); end
    ack = 1'b1;
    cyc();
    ack = 1'b0; din_ok = 1'b1; din = 16'h3333;
    cyc();
    din = 16'h4444;
    cyc();
    din_ok = 1'b0;
    #1;
    checks++; if (ok0 !== 1'b1 || dout0 !== 32'h44443333) begin errors++; $display("FAIL chg_second_fill: got ok=%b dout=%h expected ok=1 dout=44443333", ok0, dout0); end
  endtask

  task automatic test_cs_drop();
    cs = 1'b1; addr = 15'h0040;
    cyc();
    checks++; if (req0 !== 1'b1 || sa0 !== 22'h000080) begin errors++; $display("FAIL drop_req: got req=%b addr=%h expected req=1 addr=000080", req0, sa0); end
    // A beat coinciding with ack must not be taken as the first beat.
    cs = 1'b0; ack = 1'b1; din_ok = 1'b1; din = 16'hDEAD;
    cyc();
    ack = 1'b0; din = 16'h7777;
    cyc();
    din = 16'h8888;
    cyc();
    din_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (req0 !== 1'b0) begin errors++; $display("FAIL drop_no_new_req: got %b expected 0", req0); end
    end
    cs = 1'b1; addr = 15'h0040;
    #1;
    checks++; if (ok0 !== 1'b1 || dout0 !== 32'h88887777) begin errors++; $display("FAIL drop_later_hit: got ok=%b dout=%h expected ok=1 dout=88887777", ok0, dout0); end
  endtask

  task automatic test_reset_mid();
    addr = 15'h0050;
    cyc();
    checks++; if (req0 !== 1'b1 || sa0 !== 22'h0000A0) begin errors++; $display("FAIL rmid_req: got req=%b addr=%h expected req=1 addr=0000a0", req0, sa0); end
    ack = 1'b1;
    cyc();
    ack = 1'b0; din_ok = 1'b1; din = 16'h9999;
    cyc();
    din_ok = 1'b0; rst = 1'b1; cs = 1'b0;
    cyc();
    rst = 1'b0;
    checks++; if (req0 !== 1'b0) begin errors++; $display("FAIL rmid_req_drop: got %b expected 0", req0); end
    checks++; if (dout0 !== 32'h0) begin errors++; $display("FAIL rmid_dout_clear: got %h expected 00000000", dout0); end
    din_ok = 1'b1; din = 16'hAAAA;
    cyc();
    din_ok = 1'b0;
    cs = 1'b1; addr = 15'h0050;
    #1;
    checks++; if (ok0 !== 1'b0) begin errors++; $display("FAIL rmid_ok_low: got %b expected 0", ok0); end
    cyc();
    checks++; if (req0 !== 1'b1 || sa0 !== 22'h0000A0) begin errors++; $display("FAIL rmid_refetch: got req=%b addr=%h expected req=1 addr=0000a0", req0, sa0); end
    ack = 1'b1;
    cyc();
    ack = 1'b0; din_ok = 1'b1; din = 16'hBBBB;
    cyc();
    din = 16'hCCCC;
    cyc();
    din_ok = 1'b0;
    #1;
    checks++; if (ok0 !== 1'b1 || dout0 !== 32'hCCCCBBBB) begin errors++; $display("FAIL rmid_refill: got ok=%b dout=%h expected ok=1 dout=ccccbbbb", ok0, dout0); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_offset();
    test_addr_change();
    test_cs_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
